// File: rtl/dram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port DRAM with 1-cycle read latency.
// One command in flight: grant, drive the port for one cycle, capture dout, hand the result back.
//
// state   | meaning
// IDLE    | waiting for a request; grants one combinationally
// ISSUE   | memory port driven with the latched command for exactly one cycle
// CAPTURE | mem_dout valid; latched into resp_data
// RESP    | resp_valid to owner until owner's resp_ready
module dram_port_arbiter #(
  parameter int DATA = 32,
  parameter int ADDR = 28
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_0,
  output logic            req_ready_0,
  input  logic            req_wr_0,
  input  logic [ADDR-1:0] req_addr_0,
  input  logic [DATA-1:0] req_din_0,
  output logic            resp_valid_0,
  input  logic            resp_ready_0,
  input  logic            req_valid_1,
  output logic            req_ready_1,
  input  logic            req_wr_1,
  input  logic [ADDR-1:0] req_addr_1,
  input  logic [DATA-1:0] req_din_1,
  output logic            resp_valid_1,
  input  logic            resp_ready_1,
  output logic [DATA-1:0] resp_data,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state, state_nxt;
  logic            rr_ptr;
  logic            owner;
  logic            cmd_wr;
  logic [ADDR-1:0] cmd_addr;
  logic [DATA-1:0] cmd_din;
  logic            grant_any;
  logic            grant_sel;

  always_comb begin
    state_nxt    = state;
    grant_any    = 1'b0;
    grant_sel    = 1'b0;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    resp_valid_0 = 1'b0;
    resp_valid_1 = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_0 || req_valid_1) begin
          grant_any   = 1'b1;
          // Contention resolved by rr_ptr; a lone requester always wins.
          grant_sel   = (req_valid_0 && req_valid_1) ? rr_ptr : req_valid_1;
          req_ready_0 = ~reset & ~grant_sel;
          req_ready_1 = ~reset & grant_sel;
          state_nxt   = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        resp_valid_0 = ~reset & ~owner;
        resp_valid_1 = ~reset & owner;
        if (owner ? resp_ready_1 : resp_ready_0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the write strobe immediately so an aborted ISSUE never reaches the DRAM.
  assign mem_wr   = (state == ISSUE) & cmd_wr & ~reset;
  assign mem_addr = cmd_addr;
  assign mem_din  = cmd_din;
  assign busy     = (state != IDLE) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_din   <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      if (grant_any) begin
        owner    <= grant_sel;
        rr_ptr   <= ~grant_sel;
        cmd_wr   <= grant_sel ? req_wr_1   : req_wr_0;
        cmd_addr <= grant_sel ? req_addr_1 : req_addr_0;
        cmd_din  <= grant_sel ? req_din_1  : req_din_0;
      end
      if (state == CAPTURE) resp_data <= mem_dout;
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed scenarios plus randomized traffic against a shadow-memory
// and round-robin model; includes a 1-cycle write-first DRAM model.
module tb_dram_port_arbiter;
  localparam int DATA = 32;
  localparam int ADDR = 28;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid_0, req_ready_0, req_wr_0, resp_valid_0, resp_ready_0;
  logic [ADDR-1:0] req_addr_0;
  logic [DATA-1:0] req_din_0;
  logic            req_valid_1, req_ready_1, req_wr_1, resp_valid_1, resp_ready_1;
  logic [ADDR-1:0] req_addr_1;
  logic [DATA-1:0] req_din_1;
  logic [DATA-1:0] resp_data;
  logic            mem_wr;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_din;
  logic [DATA-1:0] mem_dout;
  logic            busy;

  logic [DATA-1:0] dram   [256];
  logic [DATA-1:0] shadow [256];
  logic            pre_we = 1'b0;
  logic [7:0]      pre_addr = '0;
  logic [DATA-1:0] pre_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Write-first DRAM, 1-cycle read latency; pre_* is a bench-only backdoor used while the DUT is idle.
  always @(posedge clk) begin
    if (mem_wr) dram[mem_addr[7:0]] <= mem_din;
    else if (pre_we) dram[pre_addr] <= pre_data;
    mem_dout <= mem_wr ? mem_din : dram[mem_addr[7:0]];
  end

  dram_port_arbiter #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_wr_0(req_wr_0),
    .req_addr_0(req_addr_0), .req_din_0(req_din_0),
    .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_wr_1(req_wr_1),
    .req_addr_1(req_addr_1), .req_din_1(req_din_1),
    .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
    .resp_data(resp_data), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input bit r, input bit v, input bit wr, input logic [ADDR-1:0] a,
                         input logic [DATA-1:0] d);
    if (!r) begin
      req_valid_0 = v; req_wr_0 = wr; req_addr_0 = a; req_din_0 = d;
    end else begin
      req_valid_1 = v; req_wr_1 = wr; req_addr_1 = a; req_din_1 = d;
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [DATA-1:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
    shadow[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 30) begin step(); n++; end
  endtask

  // Drives one command with resp_ready already high; reports accept->response latency, mem_wr cycles, data.
  task automatic run_cmd(input bit r, input bit wr, input logic [ADDR-1:0] a, input logic [DATA-1:0] d,
                         output int lat, output int wrs, output logic [DATA-1:0] data);
    int n;
    lat = -1; wrs = 0; data = '0;
    set_req(r, 1'b1, wr, a, d);
    #1;
    n = 0;
    while (!(r ? req_ready_1 : req_ready_0) && n < 20) begin step(); n++; end
    step();
    set_req(r, 1'b0, wr, a, d);
    #1;
    if (n >= 20) return;
    n = 1;
    while (!(r ? resp_valid_1 : resp_valid_0) && n < 20) begin
      wrs += int'(mem_wr);
      step();
      n++;
    end
    if (n < 20) begin lat = n; data = resp_data; end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    step(); step();
    set_req(0, 1'b1, 1'b0, 28'h5, '0);
    #1;
    total++; if (req_ready_0 !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready_0); end
    total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL reset_mem_wr got=%b want=0", mem_wr); end
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({resp_valid_0, resp_valid_1} !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b want=00", {resp_valid_0, resp_valid_1}); end
    total++; if (mem_addr !== '0 || mem_din !== '0) begin bad++; $display("FAIL reset_mem_port got=%h/%h want=0/0", mem_addr, mem_din); end
    total++; if (resp_data !== '0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
  endtask

  task automatic test_read_latency();
    int n;
    preload(8'h10, 32'hDEADBEEF);
    set_req(0, 1'b1, 1'b0, 28'h10, '0);
    #1;
    n = 0;
    while (!req_ready_0 && n < 20) begin step(); n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL read_grant_delay got=%0d want=0", n); end
    step();
    set_req(0, 1'b0, 1'b0, 28'h10, '0);
    #1;
    total++; if (mem_addr !== 28'h10 || mem_wr !== 1'b0) begin bad++; $display("FAIL read_issue got=addr %h wr %b want=addr 10 wr 0", mem_addr, mem_wr); end
    total++; if (req_ready_0 !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL read_busy got=rdy %b busy %b want=0 1", req_ready_0, busy); end
    step();
    total++; if (resp_valid_0 !== 1'b0) begin bad++; $display("FAIL read_early_resp got=%b want=0", resp_valid_0); end
    step();
    total++; if (resp_valid_0 !== 1'b1 || resp_valid_1 !== 1'b0) begin bad++; $display("FAIL read_resp_valid got=%b%b want=10", resp_valid_0, resp_valid_1); end
    total++; if (resp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL read_resp_data got=%h want=deadbeef", resp_data); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_back_idle got=%b want=0", busy); end
  endtask

  task automatic test_write();
    int lat, wrs;
    logic [DATA-1:0] data;
    run_cmd(1, 1'b1, 28'h20, 32'h12345678, lat, wrs, data);
    shadow[8'h20] = 32'h12345678;
    total++; if (lat !== 3) begin bad++; $display("FAIL write_latency got=%0d want=3", lat); end
    total++; if (wrs !== 1) begin bad++; $display("FAIL write_mem_wr_cycles got=%0d want=1", wrs); end
    total++; if (data !== 32'h12345678) begin bad++; $display("FAIL write_resp_data got=%h want=12345678", data); end
    total++; if (dram[8'h20] !== 32'h12345678) begin bad++; $display("FAIL write_mem_content got=%h want=12345678", dram[8'h20]); end
    run_cmd(0, 1'b0, 28'h20, '0, lat, wrs, data);
    total++; if (data !== 32'h12345678 || wrs !== 0) begin bad++; $display("FAIL write_readback got=%h wr %0d want=12345678 wr 0", data, wrs); end
  endtask

  task automatic test_fairness();
    int grants[$];
    int times[$];
    int n, exp_g;
    do_reset();
    set_req(0, 1'b1, 1'b0, 28'h40, '0);
    set_req(1, 1'b1, 1'b0, 28'h41, '0);
    #1;
    n = 0;
    while (grants.size() < 6 && n < 80) begin
      total++; if (req_ready_0 && req_ready_1) begin bad++; $display("FAIL fair_double_grant got=11 want=one-hot"); end
      if (req_ready_0) begin grants.push_back(0); times.push_back(n); end
      else if (req_ready_1) begin grants.push_back(1); times.push_back(n); end
      step();
      n++;
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_idle();
    total++; if (grants.size() !== 6) begin bad++; $display("FAIL fair_grant_count got=%0d want=6", grants.size()); end
    exp_g = 0;
    foreach (grants[i]) begin
      total++; if (grants[i] !== exp_g) begin bad++; $display("FAIL fair_order idx %0d got=%0d want=%0d", i, grants[i], exp_g); end
      if (i > 0) begin
        total++; if (times[i] - times[i-1] !== 4) begin bad++; $display("FAIL fair_spacing idx %0d got=%0d want=4", i, times[i] - times[i-1]); end
      end
      exp_g = 1 - exp_g;
    end
  endtask

  task automatic test_backpressure();
    int n;
    resp_ready_0 = 1'b0;
    set_req(0, 1'b1, 1'b0, 28'h10, '0);
    #1;
    n = 0;
    while (!req_ready_0 && n < 20) begin step(); n++; end
    step();
    set_req(0, 1'b0, 1'b0, 28'h10, '0);
    set_req(1, 1'b1, 1'b0, 28'h20, '0);
    #1;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      total++; if (resp_valid_0 !== 1'b1 || resp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bp_hold cyc %0d got=%b %h want=1 deadbeef", i, resp_valid_0, resp_data); end
      total++; if (req_ready_1 !== 1'b0) begin bad++; $display("FAIL bp_no_grant cyc %0d got=%b want=0", i, req_ready_1); end
      step();
    end
    resp_ready_0 = 1'b1;
    #1;
    step();
    total++; if (req_ready_1 !== 1'b1 || resp_valid_0 !== 1'b0) begin bad++; $display("FAIL bp_release got=rdy1 %b rv0 %b want=1 0", req_ready_1, resp_valid_0); end
    step();
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_idle();
  endtask

  task automatic test_reset_issue();
    int n, lat, wrs;
    logic [DATA-1:0] data;
    preload(8'h30, 32'h00000055);
    set_req(0, 1'b1, 1'b1, 28'h30, 32'hAA);
    #1;
    n = 0;
    while (!req_ready_0 && n < 20) begin step(); n++; end
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    total++; if (mem_wr !== 1'b1) begin bad++; $display("FAIL rst_issue_wr_before got=%b want=1", mem_wr); end
    reset = 1'b1;
    #1;
    total++; if (mem_wr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_issue_gate got=wr %b busy %b want=0 0", mem_wr, busy); end
    step();
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || mem_addr !== '0) begin bad++; $display("FAIL rst_issue_idle got=busy %b addr %h want=0 0", busy, mem_addr); end
    total++; if (dram[8'h30] !== 32'h55) begin bad++; $display("FAIL rst_issue_mem got=%h want=55", dram[8'h30]); end
    n = 0;
    for (int i = 0; i < 4; i++) begin n += int'(resp_valid_0 | resp_valid_1); step(); end
    total++; if (n !== 0) begin bad++; $display("FAIL rst_issue_discard got=%0d resp cycles want=0", n); end
    run_cmd(0, 1'b0, 28'h30, '0, lat, wrs, data);
    total++; if (data !== 32'h55 || lat !== 3) begin bad++; $display("FAIL rst_issue_after got=%h lat %0d want=55 lat 3", data, lat); end
  endtask

  task automatic test_nonowner_ready();
    int n;
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b0;
    set_req(0, 1'b1, 1'b0, 28'h20, '0);
    #1;
    n = 0;
    while (!req_ready_0 && n < 20) begin step(); n++; end
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    step(); step();
    resp_ready_1 = 1'b1;
    #1;
    step();
    resp_ready_1 = 1'b0;
    #1;
    total++; if (resp_valid_0 !== 1'b1 || busy !== 1'b1 || resp_valid_1 !== 1'b0) begin bad++; $display("FAIL nonowner_ignored got=rv0 %b busy %b rv1 %b want=1 1 0", resp_valid_0, busy, resp_valid_1); end
    total++; if (resp_data !== 32'h12345678) begin bad++; $display("FAIL nonowner_data got=%h want=12345678", resp_data); end
    resp_ready_0 = 1'b1;
    #1;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nonowner_release got=%b want=0", busy); end
    resp_ready_1 = 1'b1;
  endtask

  task automatic test_random();
    bit              pend [2];
    bit              wr   [2];
    logic [ADDR-1:0] ad   [2];
    logic [DATA-1:0] dn   [2];
    bit              pref, w, exp_w;
    logic [DATA-1:0] exp_d;
    int              n, hold;
    for (int a = 8'h80; a < 8'h90; a++) preload(a[7:0], $urandom);
    do_reset();
    pref = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1; wr[r] = 1'($urandom_range(0, 1));
          ad[r] = 28'h80 + 28'($urandom_range(0, 15)); dn[r] = $urandom;
        end
      end
      if (!pend[0] && !pend[1]) begin
        n = int'($urandom_range(0, 1));
        pend[n] = 1'b1; wr[n] = 1'($urandom_range(0, 1));
        ad[n] = 28'h80 + 28'($urandom_range(0, 15)); dn[n] = $urandom;
      end
      set_req(0, pend[0], wr[0], ad[0], dn[0]);
      set_req(1, pend[1], wr[1], ad[1], dn[1]);
      #1;
      n = 0;
      while (!req_ready_0 && !req_ready_1 && n < 20) begin step(); n++; end
      total++;
      if (n >= 20) begin bad++; $display("FAIL rand_grant_timeout iter %0d got=no grant want=grant", k); break; end
      w = req_ready_1;
      exp_w = (pend[0] && pend[1]) ? pref : pend[1];
      pref = ~exp_w;
      if (w !== exp_w) begin bad++; $display("FAIL rand_winner iter %0d got=%0d want=%0d", k, w, exp_w); end
      if (wr[w]) begin shadow[ad[w][7:0]] = dn[w]; exp_d = dn[w]; end
      else exp_d = shadow[ad[w][7:0]];
      pend[w] = 1'b0;
      if (w) resp_ready_1 = 1'b0; else resp_ready_0 = 1'b0;
      step();
      set_req(w, 1'b0, 1'b0, '0, '0);
      #1;
      total++; if (mem_wr !== wr[w] || mem_addr !== ad[w]) begin bad++; $display("FAIL rand_issue iter %0d got=wr %b addr %h want=wr %b addr %h", k, mem_wr, mem_addr, wr[w], ad[w]); end
      step();
      total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rand_wr_pulse iter %0d got=%b want=0", k, mem_wr); end
      step();
      total++; if ({resp_valid_1, resp_valid_0} !== (w ? 2'b10 : 2'b01) || resp_data !== exp_d) begin bad++; $display("FAIL rand_resp iter %0d got=v %b%b d %h want=owner %0d d %h", k, resp_valid_1, resp_valid_0, resp_data, w, exp_d); end
      hold = int'($urandom_range(0, 3));
      for (int i = 0; i < hold; i++) step();
      total++; if ((w ? resp_valid_1 : resp_valid_0) !== 1'b1 || resp_data !== exp_d) begin bad++; $display("FAIL rand_hold iter %0d got=%h want=%h", k, resp_data, exp_d); end
      resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
      #1;
      step();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_fairness();
    test_backpressure();
    test_reset_issue();
    test_nonowner_ready();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
